// File: rtl/cmpl_mul_arbiter_pkg.sv
// Shared types and constants for the complex-multiplier scheduler.
package cmpl_mul_pkg;

  localparam int DW        = 18;
  localparam int MUL_LAT   = 2;
  localparam int N_REQ_MAX = 8;
  localparam int ID_W      = $clog2(N_REQ_MAX);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cmpl_op_t;

  typedef struct packed {
    logic [ID_W-1:0]        id;
    logic signed [2*DW-1:0] re;
    logic signed [2*DW-1:0] im;
  } cmpl_res_t;

endpackage

// File: rtl/cmpl_mul_arbiter_if.sv
// Requester, multiplier and result-stream signals of the complex-multiplier scheduler.
interface cmpl_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = cmpl_mul_pkg::DW
) ();

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a_real;
  logic [N_REQ*DW-1:0] req_a_imag;
  logic [N_REQ*DW-1:0] req_b_real;
  logic [N_REQ*DW-1:0] req_b_imag;

  logic [DW-1:0]       mul_a_real;
  logic [DW-1:0]       mul_a_imag;
  logic [DW-1:0]       mul_b_real;
  logic [DW-1:0]       mul_b_imag;
  logic [2*DW-1:0]     mul_res_real;
  logic [2*DW-1:0]     mul_res_imag;

  logic                out_valid;
  logic                out_ready;
  logic [IDW-1:0]      out_id;
  logic [2*DW-1:0]     out_real;
  logic [2*DW-1:0]     out_imag;

  modport slave (
    input  req_valid, req_a_real, req_a_imag, req_b_real, req_b_imag,
    input  mul_res_real, mul_res_imag, out_ready,
    output req_ready, mul_a_real, mul_a_imag, mul_b_real, mul_b_imag,
    output out_valid, out_id, out_real, out_imag
  );

  modport master (
    output req_valid, req_a_real, req_a_imag, req_b_real, req_b_imag,
    output mul_res_real, mul_res_imag, out_ready,
    input  req_ready, mul_a_real, mul_a_imag, mul_b_real, mul_b_imag,
    input  out_valid, out_id, out_real, out_imag
  );

endinterface

// File: rtl/cmpl_mul_arbiter_res_fifo.sv
// Result FIFO with first-word-fall-through head and occupancy count.
module cmpl_res_fifo import cmpl_mul_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  cmpl_res_t        din,
  input  logic             pop,
  output cmpl_res_t        dout,
  output logic [CNT_W-1:0] count
);

  cmpl_res_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           empty;
  logic           pop_en;

  assign empty  = (count == '0);
  assign pop_en = pop & ~empty;
  // Head reads as zero while empty so the output bus is clean out of reset.
  assign dout   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
                                  (push && count == CNT_W'(DEPTH)) |-> pop)
    else $error("result FIFO overflow");

endmodule

// File: rtl/cmpl_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined complex multiplier among N_REQ requesters,
// with an ID tag pipeline and a credit-protected result FIFO.
module cmpl_mul_arbiter import cmpl_mul_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int DW         = cmpl_mul_pkg::DW,
  parameter int MUL_LAT    = cmpl_mul_pkg::MUL_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clock,
  input logic               rst_n,
  cmpl_mul_arbiter_if.slave bus
);

  localparam int           IDW   = $clog2(N_REQ);
  localparam int           CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDW:0] N_L   = (IDW+1)'(N_REQ);

  logic [IDW-1:0]              rr_ptr;
  logic [IDW-1:0]              gnt_idx;
  logic [IDW:0]                arb_idx;
  logic                        gnt_any;
  logic                        credit_ok;
  logic                        accept;
  logic                        pop;
  logic [N_REQ-1:0]            grant;
  int unsigned                 used;
  logic [MUL_LAT:0]            tag_v;
  logic [MUL_LAT:0][IDW-1:0]   tag_id;
  cmpl_op_t                    req_a [N_REQ];
  cmpl_op_t                    req_b [N_REQ];
  cmpl_op_t                    op_a;
  cmpl_op_t                    op_b;
  logic [CNT_W-1:0]            fifo_count;
  cmpl_res_t                   push_data;
  cmpl_res_t                   head;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_a[g] = '{re: bus.req_a_real[g*DW +: DW], im: bus.req_a_imag[g*DW +: DW]};
    assign req_b[g] = '{re: bus.req_b_real[g*DW +: DW], im: bus.req_b_imag[g*DW +: DW]};
  end

  assign pop = bus.out_valid & bus.out_ready;

  // FIFO count plus valid tags is every result already owed a slot; a head leaving
  // this cycle frees its slot well before a grant made now can reach the FIFO.
  always_comb begin
    used      = 32'(fifo_count) + 32'($countones(tag_v));
    credit_ok = rst_n && (used < 32'(FIFO_DEPTH) + 32'(pop));
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    arb_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      arb_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (arb_idx >= N_L) arb_idx = arb_idx - N_L;
      if (!gnt_any && bus.req_valid[arb_idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_idx[IDW-1:0];
      end
    end
    grant = '0;
    if (gnt_any && credit_ok) grant[gnt_idx] = 1'b1;
  end

  assign accept        = gnt_any & credit_ok;
  assign bus.req_ready = grant;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDW'(N_REQ - 1);
      tag_v  <= '0;
      tag_id <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      tag_v  <= {tag_v[MUL_LAT-1:0], accept};
      tag_id <= {tag_id[MUL_LAT-1:0], gnt_idx};
      if (accept) begin
        rr_ptr <= gnt_idx;
        op_a   <= req_a[gnt_idx];
        op_b   <= req_b[gnt_idx];
      end
    end
  end

  assign bus.mul_a_real = op_a.re;
  assign bus.mul_a_imag = op_a.im;
  assign bus.mul_b_real = op_b.re;
  assign bus.mul_b_imag = op_b.im;

  always_comb begin
    push_data.id = ID_W'(tag_id[MUL_LAT]);
    push_data.re = bus.mul_res_real;
    push_data.im = bus.mul_res_imag;
  end

  cmpl_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (tag_v[MUL_LAT]),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count)
  );

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_id    = IDW'(head.id);
  assign bus.out_real  = head.re;
  assign bus.out_imag  = head.im;

endmodule
